// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: datapath width, the canonical NOP and the
// {pc, instr} entry carried from instruction memory to decode.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response channel and decode hand-off channel of
// the fetch stage; master is the fetch unit, slave is the memory/decode side.
interface ifetch_if;
    import rv32i_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH is a power of two so pointers wrap
// naturally. Simultaneous push and pop is accepted even when full.
module ifetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0],
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  T              din_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output T              dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Next pointers and occupancy; flush wins over any push or pop.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + PW'(do_push);
            rptr_d  = rptr_q + PW'(do_pop);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while the entry is counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: issues credit-limited in-order requests, tracks
// in-flight addresses, buffers responses for decode and drops stale ones.
module ifetch
    import rv32i_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_advance,
    input  logic            flush,
    output logic            fetch_misaligned,
    ifetch_if.master        bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   occupancy;
    logic [CW+1:0]   used;
    logic            credit_ok;
    logic            misaligned;
    logic            req;
    logic            gnt_fire;
    logic            rsp_take;
    logic            rsp_live;
    logic            pop;
    logic            infl_full, infl_empty;
    logic            buf_full, buf_empty;
    logic [XLEN-1:0] head_pc;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    head_entry;

    // Request, credit and response-routing decisions; drop_cnt bookkeeping.
    always_comb begin
        used       = {2'b00, outstanding} + {2'b00, drop_q} + {2'b00, occupancy};
        credit_ok  = (used < (CW+2)'(DEPTH)) && !infl_full;
        misaligned = (pc_in[1:0] != 2'b00);
        req        = !rst && !flush && !misaligned && credit_ok;
        gnt_fire   = req && bus.imem_gnt;
        pop        = !buf_empty && bus.id_ready;
        rsp_live   = bus.imem_rvalid && ((drop_q != '0) || !infl_empty);
        rsp_take   = bus.imem_rvalid && (drop_q == '0) && !infl_empty && !flush
                     && (!buf_full || pop);
        rsp_entry.pc    = head_pc;
        rsp_entry.instr = bus.imem_rdata;
        // On flush every live fetch becomes a pending drop, minus this cycle's response.
        if (flush) begin
            drop_d = drop_q + outstanding - CW'(rsp_live);
        end else if (bus.imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end else begin
            drop_d = drop_q;
        end
    end

    // Stale-response counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_inflight (
        .clk     (clk),
        .rst     (rst),
        .push_i  (gnt_fire),
        .din_i   (pc_in),
        .pop_i   (rsp_take),
        .flush_i (flush),
        .dout_o  (head_pc),
        .full_o  (infl_full),
        .empty_o (infl_empty),
        .count_o (outstanding)
    );

    ifetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_take),
        .din_i   (rsp_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .dout_o  (head_entry),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (occupancy)
    );

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc_in;
    assign pc_advance     = gnt_fire;
    assign fetch_misaligned = misaligned && !flush;
    assign bus.id_valid   = !buf_empty;
    assign bus.id_instr   = buf_empty ? NOP_INSTR : head_entry.instr;
    assign bus.id_pc      = buf_empty ? RESET_PC  : head_entry.pc;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch (DEPTH=2): in-order memory responder one cycle
// after each grant, scenario tasks with hand-computed expectations.
module tb_ifetch;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        fetch_misaligned;
    int          vec_cnt = 0;
    int          err_cnt = 0;
    bit          rsp_en;
    logic [31:0] pend_q[$];

    ifetch_if bus();

    ifetch #(.DEPTH(2), .RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_in            (pc_in),
        .pc_advance       (pc_advance),
        .flush            (flush),
        .fetch_misaligned (fetch_misaligned),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: records grants at negedge, answers in order one cycle later.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && bus.imem_req && bus.imem_gnt) pend_q.push_back(bus.imem_addr);
            @(posedge clk); #1;
            if (rst) begin
                pend_q.delete();
                bus.imem_rvalid = 1'b0;
            end else if (rsp_en && pend_q.size() > 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = instr_of(pend_q.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'h0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; pc_in = 32'h0; rsp_en = 1'b1;
        bus.imem_gnt = 1'b1; bus.id_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (bus.id_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_id_valid: got %0b expected 0", bus.id_valid); end
        vec_cnt++; if (bus.imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_imem_req: got %0b expected 0", bus.imem_req); end
        vec_cnt++; if (pc_advance !== 1'b0) begin err_cnt++; $display("FAIL reset_pc_advance: got %0b expected 0", pc_advance); end
        vec_cnt++; if (bus.id_instr !== 32'h0000_0013) begin err_cnt++; $display("FAIL reset_id_instr: got %h expected 00000013", bus.id_instr); end
        vec_cnt++; if (bus.id_pc !== RST_PC) begin err_cnt++; $display("FAIL reset_id_pc: got %h expected %h", bus.id_pc, RST_PC); end
        @(posedge clk); #1;
        rst = 1'b0; bus.imem_gnt = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.imem_req !== 1'b1) begin err_cnt++; $display("FAIL release_first_req: got %0b expected 1", bus.imem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        logic [31:0] seen_pc[$];
        logic [31:0] seen_in[$];
        int          seen_cyc[$];
        bit          adv;
        pc_in = 32'h0; bus.id_ready = 1'b1; bus.imem_gnt = 1'b1; rsp_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.id_valid && bus.id_ready) begin
                seen_pc.push_back(bus.id_pc);
                seen_in.push_back(bus.id_instr);
                seen_cyc.push_back(c);
            end
            adv = pc_advance;
            @(posedge clk); #1;
            if (adv) pc_in = pc_in + 32'd4;
            if (pc_in == 32'd12) bus.imem_gnt = 1'b0;
        end
        vec_cnt++; if (seen_pc.size() != 3) begin err_cnt++; $display("FAIL stream_count: got %0d expected 3", seen_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (seen_pc.size() > i) begin
                vec_cnt++; if (seen_pc[i] !== 32'(4 * i)) begin err_cnt++; $display("FAIL stream_pc%0d: got %h expected %h", i, seen_pc[i], 32'(4 * i)); end
                vec_cnt++; if (seen_in[i] !== instr_of(32'(4 * i))) begin err_cnt++; $display("FAIL stream_instr%0d: got %h expected %h", i, seen_in[i], instr_of(32'(4 * i))); end
            end
        end
        if (seen_cyc.size() >= 2) begin
            vec_cnt++; if (seen_cyc[0] != 2) begin err_cnt++; $display("FAIL stream_fill: got cycle %0d expected 2", seen_cyc[0]); end
            vec_cnt++; if (seen_cyc[1] != 3) begin err_cnt++; $display("FAIL stream_next: got cycle %0d expected 3", seen_cyc[1]); end
        end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        bit adv;
        bus.id_ready = 1'b0; pc_in = 32'h20; bus.imem_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) grants++;
            adv = pc_advance;
            if (c == 5) begin
                vec_cnt++; if (bus.imem_req !== 1'b0) begin err_cnt++; $display("FAIL bp_req_stalled: got %0b expected 0", bus.imem_req); end
            end
            @(posedge clk); #1;
            if (adv) pc_in = pc_in + 32'd4;
        end
        vec_cnt++; if (grants != 2) begin err_cnt++; $display("FAIL bp_grants: got %0d expected 2", grants); end
        bus.id_ready = 1'b1; bus.imem_gnt = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.id_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_pop_valid: got %0b expected 1", bus.id_valid); end
        vec_cnt++; if (bus.id_pc !== 32'h20) begin err_cnt++; $display("FAIL bp_pop_pc: got %h expected 00000020", bus.id_pc); end
        vec_cnt++; if (bus.imem_req !== 1'b0) begin err_cnt++; $display("FAIL bp_no_comb_credit: got %0b expected 0", bus.imem_req); end
        @(posedge clk); #1;
        @(negedge clk);
        vec_cnt++; if (bus.imem_req !== 1'b1) begin err_cnt++; $display("FAIL bp_credit_return: got %0b expected 1", bus.imem_req); end
        vec_cnt++; if (bus.id_pc !== 32'h24) begin err_cnt++; $display("FAIL bp_second_pc: got %h expected 00000024", bus.id_pc); end
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_flush_inflight();
        bit          adv;
        bit          bad_seen = 1'b0;
        int          n_seen = 0;
        logic [31:0] first_pc = 32'hFFFF_FFFF;
        logic [31:0] first_in = 32'hFFFF_FFFF;
        rsp_en = 1'b0; bus.id_ready = 1'b1; pc_in = 32'h10; bus.imem_gnt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            adv = pc_advance;
            @(posedge clk); #1;
            if (adv) pc_in = pc_in + 32'd4;
        end
        flush = 1'b1;
        @(negedge clk);
        vec_cnt++; if (bus.imem_req !== 1'b0) begin err_cnt++; $display("FAIL flush_req_blocked: got %0b expected 0", bus.imem_req); end
        rsp_en = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; pc_in = 32'h100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.id_valid) begin
                if (n_seen == 0) begin first_pc = bus.id_pc; first_in = bus.id_instr; end
                if (bus.id_pc == 32'h10 || bus.id_pc == 32'h14) bad_seen = 1'b1;
                n_seen++;
            end
            adv = pc_advance;
            @(posedge clk); #1;
            if (adv) pc_in = pc_in + 32'd4;
            if (pc_in >= 32'h108) bus.imem_gnt = 1'b0;
        end
        vec_cnt++; if (first_pc !== 32'h100) begin err_cnt++; $display("FAIL flush_next_pc: got %h expected 00000100", first_pc); end
        vec_cnt++; if (first_in !== instr_of(32'h100)) begin err_cnt++; $display("FAIL flush_next_instr: got %h expected %h", first_in, instr_of(32'h100)); end
        vec_cnt++; if (bad_seen !== 1'b0) begin err_cnt++; $display("FAIL flush_stale_seen: got %0b expected 0", bad_seen); end
        vec_cnt++; if (n_seen != 2) begin err_cnt++; $display("FAIL flush_count: got %0d expected 2", n_seen); end
    endtask

    task automatic test_flush_rvalid_pop();
        bit          adv;
        int          stray = 0;
        logic [31:0] got_pc = 32'hFFFF_FFFF;
        bus.id_ready = 1'b0; bus.imem_gnt = 1'b1; pc_in = 32'h40; rsp_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            adv = pc_advance;
            @(posedge clk); #1;
            if (adv) pc_in = pc_in + 32'd4;
        end
        flush = 1'b1; bus.id_ready = 1'b1; bus.imem_gnt = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.id_valid !== 1'b1) begin err_cnt++; $display("FAIL fcoin_pop_valid: got %0b expected 1", bus.id_valid); end
        vec_cnt++; if (bus.id_pc !== 32'h40) begin err_cnt++; $display("FAIL fcoin_pop_pc: got %h expected 00000040", bus.id_pc); end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.id_valid !== 1'b0) begin err_cnt++; $display("FAIL fcoin_valid_cleared: got %0b expected 0", bus.id_valid); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.id_valid) stray++;
        end
        vec_cnt++; if (stray != 0) begin err_cnt++; $display("FAIL fcoin_stray: got %0d expected 0", stray); end
        @(posedge clk); #1;
        pc_in = 32'h80; bus.imem_gnt = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.id_valid && got_pc == 32'hFFFF_FFFF) got_pc = bus.id_pc;
            adv = pc_advance;
            @(posedge clk); #1;
            if (adv) bus.imem_gnt = 1'b0;
        end
        vec_cnt++; if (got_pc !== 32'h80) begin err_cnt++; $display("FAIL fcoin_refetch: got %h expected 00000080", got_pc); end
    endtask

    task automatic test_misaligned();
        bus.id_ready = 1'b0; bus.imem_gnt = 1'b1; pc_in = 32'h60; rsp_en = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        pc_in = 32'h102;
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            vec_cnt++; if (fetch_misaligned !== 1'b1) begin err_cnt++; $display("FAIL mis_flag%0d: got %0b expected 1", c, fetch_misaligned); end
            vec_cnt++; if (bus.imem_req !== 1'b0) begin err_cnt++; $display("FAIL mis_req%0d: got %0b expected 0", c, bus.imem_req); end
            vec_cnt++; if (pc_advance !== 1'b0) begin err_cnt++; $display("FAIL mis_adv%0d: got %0b expected 0", c, pc_advance); end
            if (c >= 2) begin
                vec_cnt++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h60) begin err_cnt++; $display("FAIL mis_buffer%0d: got %0b/%h expected 1/00000060", c, bus.id_valid, bus.id_pc); end
            end
            @(posedge clk); #1;
        end
        pc_in = 32'h104; bus.imem_gnt = 1'b0;
        @(negedge clk);
        vec_cnt++; if (bus.imem_req !== 1'b1 || fetch_misaligned !== 1'b0) begin err_cnt++; $display("FAIL mis_aligned_resume: got %0b/%0b expected 1/0", bus.imem_req, fetch_misaligned); end
        @(posedge clk); #1;
        pc_in = 32'h102; flush = 1'b1;
        @(negedge clk);
        vec_cnt++; if (fetch_misaligned !== 1'b0) begin err_cnt++; $display("FAIL mis_flush_mask: got %0b expected 0", fetch_misaligned); end
        @(posedge clk); #1;
        flush = 1'b0; bus.id_ready = 1'b1;
        @(negedge clk);
        vec_cnt++; if (bus.id_valid !== 1'b0) begin err_cnt++; $display("FAIL mis_flush_empty: got %0b expected 0", bus.id_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        bit          adv;
        logic [31:0] got_pc = 32'hFFFF_FFFF;
        bus.id_ready = 1'b0; bus.imem_gnt = 1'b1; rsp_en = 1'b0; pc_in = 32'h200;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            adv = pc_advance;
            @(posedge clk); #1;
            if (adv) pc_in = pc_in + 32'd4;
        end
        @(negedge clk);
        #2; rst = 1'b1; #1;
        vec_cnt++; if (bus.id_valid !== 1'b0) begin err_cnt++; $display("FAIL arst_id_valid: got %0b expected 0", bus.id_valid); end
        vec_cnt++; if (bus.imem_req !== 1'b0) begin err_cnt++; $display("FAIL arst_imem_req: got %0b expected 0", bus.imem_req); end
        vec_cnt++; if (pc_advance !== 1'b0) begin err_cnt++; $display("FAIL arst_pc_advance: got %0b expected 0", pc_advance); end
        vec_cnt++; if (bus.id_instr !== 32'h0000_0013) begin err_cnt++; $display("FAIL arst_id_instr: got %h expected 00000013", bus.id_instr); end
        vec_cnt++; if (bus.id_pc !== RST_PC) begin err_cnt++; $display("FAIL arst_id_pc: got %h expected %h", bus.id_pc, RST_PC); end
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; pc_in = 32'h300; rsp_en = 1'b1; bus.id_ready = 1'b1; bus.imem_gnt = 1'b1;
        @(negedge clk);
        vec_cnt++; if (bus.imem_req !== 1'b1) begin err_cnt++; $display("FAIL arst_first_req: got %0b expected 1", bus.imem_req); end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.id_valid && got_pc == 32'hFFFF_FFFF) got_pc = bus.id_pc;
            adv = pc_advance;
            @(posedge clk); #1;
            if (adv) pc_in = pc_in + 32'd4;
            if (pc_in >= 32'h308) bus.imem_gnt = 1'b0;
        end
        vec_cnt++; if (got_pc !== 32'h300) begin err_cnt++; $display("FAIL arst_no_drop: got %h expected 00000300", got_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_inflight();
        test_flush_rvalid_pop();
        test_misaligned();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
